// File: rtl/cpucr_membus_pkg.sv
// Shared constants for the CPUCR main-memory bus initiator.
// FSM state encoding, default widths and LE polarity.
package cpucr_membus_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;
  localparam int CW     = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_ADDR   = 3'd1;
  localparam logic [2:0] S_RD_CAP    = 3'd2;
  localparam logic [2:0] S_WR_SETUP  = 3'd3;
  localparam logic [2:0] S_WR_STROBE = 3'd4;
  localparam logic [2:0] S_WR_REL    = 3'd5;

  localparam logic LE_READ  = 1'b1;
  localparam logic LE_WRITE = 1'b0;

endpackage

// File: rtl/mem_bus_master_if.sv
// Core-side request/acknowledge bundle of the memory bus initiator.
// master = CPU core issuing requests, slave = mem_bus_master.
interface mem_bus_master_if
  import cpucr_membus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/mem_bus_master.sv
// CPUCR memory-bus initiator: core req/ack to Direccion/Datos/LE.
// Define MEMBUS_STATS_EN to add the n_rd/n_wr completion counters.
module mem_bus_master
  import cpucr_membus_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int RD_WAIT = 1,
  parameter int WR_TURN = 1
) (
  input  logic            CLK,
  input  logic            nRESET,
  mem_bus_master_if.slave core,
  output logic [AW-1:0]   Direccion,
  inout  wire  [DW-1:0]   Datos,
  output logic            LE
`ifdef MEMBUS_STATS_EN
  ,
  output logic [15:0]     n_rd,
  output logic [15:0]     n_wr
`endif
);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] dir_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          le_q;
  logic          drv_en_q;
  logic          rd_ack;
  logic          wr_ack;

  assign rd_ack = (state_q == S_RD_CAP);
  assign wr_ack = (state_q == S_WR_REL)
                && (cnt_q == '0);

  // Next-state and wait-counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (core.req) begin
          state_d = core.we ? S_WR_SETUP
                            : S_RD_ADDR;
          cnt_d   = CW'(RD_WAIT - 1);
        end
      end
      S_RD_ADDR: begin
        if (cnt_q == '0) state_d = S_RD_CAP;
        else cnt_d = cnt_q - CW'(1);
      end
      S_RD_CAP:    state_d = S_IDLE;
      S_WR_SETUP:  state_d = S_WR_STROBE;
      S_WR_STROBE: begin
        state_d = S_WR_REL;
        cnt_d   = CW'(WR_TURN - 1);
      end
      S_WR_REL: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State plus LE/drive enable decoded from the same next state
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      le_q     <= LE_READ;
      drv_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      le_q     <= (state_d == S_WR_STROBE)
                  ? LE_WRITE : LE_READ;
      drv_en_q <= (state_d == S_WR_STROBE);
    end
  end

  // Address/data capture on accept, read data on entry to RD_CAP
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      dir_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && core.req) begin
        dir_q <= core.addr;
        if (core.we) wdata_q <= core.wdata;
      end
      if (state_q == S_RD_ADDR
          && state_d == S_RD_CAP)
        rdata_q <= Datos;
    end
  end

`ifdef MEMBUS_STATS_EN
  logic [15:0] n_rd_q, n_wr_q;

  // Completed-transaction counters, free-running wrap
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      n_rd_q <= '0;
      n_wr_q <= '0;
    end else begin
      if (rd_ack) n_rd_q <= n_rd_q + 16'd1;
      if (wr_ack) n_wr_q <= n_wr_q + 16'd1;
    end
  end

  assign n_rd = n_rd_q;
  assign n_wr = n_wr_q;
`endif

  assign Direccion  = dir_q;
  assign LE         = le_q;
  assign Datos      = drv_en_q ? wdata_q
                               : {DW{1'bz}};
  assign core.rdata = rdata_q;
  assign core.ack   = rd_ack | wr_ack;
  assign core.busy  = (state_q != S_IDLE);

endmodule
